// File: rtl/wb_arbiter_if.sv
// Register-file write-back bus: pipeline result, mul/div handshake
// and the single write port driven by the arbiter.
interface wb_arbiter_if #(
    parameter int XLEN = 32
);
    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;

    logic            md_valid;
    logic [4:0]      md_rd;
    logic [XLEN-1:0] md_data;
    logic            md_ready;
    logic            md_pending;

    logic            we;
    logic [4:0]      waddr;
    logic [XLEN-1:0] wd;

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  md_valid, md_rd, md_data,
        output md_ready, md_pending,
        output we, waddr, wd
    );

    modport master (
        output alu_valid, alu_rd, alu_data,
        output md_valid, md_rd, md_data,
        input  md_ready, md_pending,
        input  we, waddr, wd
    );
endinterface

// File: rtl/wb_arbiter.sv
// Write-back arbiter: pipeline results own the port, mul/div results
// bypass or wait in an in-order FIFO; x0 writes are dropped here.
module wb_arbiter #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    wb_arbiter_if.slave  bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [4:0]      q_rd   [DEPTH];
    logic [XLEN-1:0] q_data [DEPTH];
    logic [CW-1:0]   count;
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;

    logic            ready;
    logic            fifo_ne;
    logic            alu_sel;
    logic            accept;
    logic            md_live;
    logic            pop;
    logic            bypass;
    logic            push;
    logic            wr_en;
    logic [4:0]      wr_rd;
    logic [XLEN-1:0] wr_data;

    // Ready depends on registered occupancy only, never on md_valid.
    assign ready          = (count != FULL);
    assign bus.md_ready   = ready;
    assign bus.md_pending = (count != '0);

    always_comb begin
        fifo_ne = (count != '0);
        alu_sel = bus.alu_valid && (bus.alu_rd != 5'd0);
        accept  = bus.md_valid && ready;
        md_live = accept && (bus.md_rd != 5'd0);
        pop     = !alu_sel && fifo_ne;
        bypass  = !alu_sel && !fifo_ne && md_live;
        push    = md_live && !bypass;
        wr_en   = alu_sel || pop || bypass;
        wr_rd   = bus.md_rd;
        wr_data = bus.md_data;
        unique case (1'b1)
            alu_sel: begin
                wr_rd   = bus.alu_rd;
                wr_data = bus.alu_data;
            end
            pop: begin
                wr_rd   = q_rd[head];
                wr_data = q_data[head];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_rd[tail]   <= bus.md_rd;
            q_data[tail] <= bus.md_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            head      <= '0;
            tail      <= '0;
            bus.we    <= 1'b0;
            bus.waddr <= 5'd0;
            bus.wd    <= '0;
        end else begin
            bus.we <= wr_en;
            if (wr_en) begin
                bus.waddr <= wr_rd;
                bus.wd    <= wr_data;
            end
            if (pop) begin
                head <= (head == LAST) ? '0 : head + PW'(1);
            end
            if (push) begin
                tail <= (tail == LAST) ? '0 : tail + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed and random checks of wb_arbiter against a queue-based
// model of the write-back priority rules.
module tb_wb_arbiter;
    localparam int XLEN  = 32;
    localparam int DEPTH = 2;

    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_arbiter_if #(.XLEN(XLEN)) bus ();

    wb_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int total  = 0;
    int passed = 0;

    ent_t            mq[$];
    logic            m_we;
    logic [4:0]      m_waddr;
    logic [XLEN-1:0] m_wd;

    task automatic chk(input string tag, input logic [XLEN-1:0] got,
                       input logic [XLEN-1:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    task automatic drive(input bit av, input int ard, input logic [31:0] ad,
                         input bit mv, input int mrd, input logic [31:0] mdat);
        bus.alu_valid = av;
        bus.alu_rd    = 5'(ard);
        bus.alu_data  = ad;
        bus.md_valid  = mv;
        bus.md_rd     = 5'(mrd);
        bus.md_data   = mdat;
    endtask

    // Next-state of the model from the current inputs.
    task automatic model_step();
        bit   rdy;
        bit   acc;
        bit   used;
        ent_t e;
        if (rst) begin
            m_we    = 1'b0;
            m_waddr = '0;
            m_wd    = '0;
            mq.delete();
            return;
        end
        rdy  = (mq.size() < DEPTH);
        acc  = bus.md_valid && rdy;
        used = 1'b0;
        if (bus.alu_valid && bus.alu_rd != 0) begin
            m_we = 1'b1; m_waddr = bus.alu_rd; m_wd = bus.alu_data;
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            m_we = 1'b1; m_waddr = e.rd; m_wd = e.data;
        end else if (acc && bus.md_rd != 0) begin
            m_we = 1'b1; m_waddr = bus.md_rd; m_wd = bus.md_data;
            used = 1'b1;
        end else begin
            m_we = 1'b0;
        end
        if (acc && bus.md_rd != 0 && !used) begin
            e.rd = bus.md_rd;
            e.data = bus.md_data;
            mq.push_back(e);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        chk("we", XLEN'(bus.we), XLEN'(m_we));
        chk("waddr", XLEN'(bus.waddr), XLEN'(m_waddr));
        chk("wd", bus.wd, m_wd);
        chk("md_ready", XLEN'(bus.md_ready), XLEN'(mq.size() != DEPTH));
        chk("md_pending", XLEN'(bus.md_pending), XLEN'(mq.size() != 0));
        model_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1, 5, 32'hAAAA_5555, 0, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_step();

        cycle();
        cycle();
        rst = 1'b0;

        drive(1, 7, 32'h1234_5678, 0, 0, 0);
        cycle();
        drive(1, 0, 32'hFFFF_FFFF, 0, 0, 0);
        cycle();
        drive(0, 0, 0, 0, 0, 0);
        cycle();

        drive(0, 0, 0, 1, 3, 32'hDEAD_BEEF);
        cycle();
        drive(0, 0, 0, 0, 0, 0);
        cycle();

        drive(1, 1, 32'h11, 1, 10, 32'hA0A0_0010);
        cycle();
        drive(1, 2, 32'h22, 1, 11, 32'hA0A0_0011);
        cycle();
        drive(1, 3, 32'h33, 1, 12, 32'hA0A0_0012);
        cycle();
        drive(1, 4, 32'h44, 1, 12, 32'hA0A0_0012);
        cycle();
        drive(0, 0, 0, 1, 12, 32'hA0A0_0012);
        cycle();
        cycle();
        drive(0, 0, 0, 0, 0, 0);
        cycle();
        cycle();

        drive(0, 0, 0, 1, 0, 32'hBAD0_0000);
        cycle();

        drive(1, 9, 32'h99, 1, 12, 32'hC0DE_0012);
        cycle();
        drive(0, 0, 0, 1, 13, 32'hC0DE_0013);
        cycle();
        drive(0, 0, 0, 0, 0, 0);
        cycle();
        cycle();

        drive(1, 6, 32'h66, 1, 20, 32'hF00D_0020);
        cycle();
        drive(1, 8, 32'h88, 1, 21, 32'hF00D_0021);
        cycle();
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        cycle();
        cycle();

        for (int i = 0; i < 600; i++) begin
            int ard;
            int mrd;
            ard = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 31);
            mrd = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 31);
            drive($urandom_range(0, 1) == 1, ard, $urandom,
                  $urandom_range(0, 2) != 0, mrd, $urandom);
            rst = ($urandom_range(0, 49) == 0);
            cycle();
        end
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        cycle();
        cycle();
        cycle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
